usb11_serializer: RTL and testbench

- Full-speed (12 Mb/s) USB 1.1 packet transmitter: accepts bytes over a write/next handshake, serializes them LSB-first with bit stuffing and NRZI, and appends EOP.
- Drives dp/dm with an output-enable (bus_enable) for the host port.
- Also used as the attached-device model in benches.
- Also provides a 1 ms frame timer (eof/eof_ena) and a low-speed bit strobe.
- Sync byte (0x80) and PID are supplied by the user as ordinary data bytes.

---
 rtl/usb11_serializer.sv | 137 +++++++++++++
 tb/tb_usb11_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/usb11_serializer.sv
// usb11_serializer: full-speed USB packet transmitter (LSB-first, bit stuffing, NRZI, EOP)
// with a free-running 1 ms frame timer and a low-speed bit strobe.
module usb11_serializer #(
    parameter int FRAME_LEN = 12000,
    parameter int EOF_GUARD = 64,
    parameter int LS_DIV    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sbyte,
    input  logic       sbyte_wr,
    input  logic       last_pkt_byte,
    output logic       dp,
    output logic       dm,
    output logic       bus_enable,
    output logic       show_next,
    output logic       pkt_end,
    output logic       ls_bit_time,
    output logic       eof,
    output logic       eof_ena
);
    localparam int FW = $clog2(FRAME_LEN);
    localparam int LW = $clog2(LS_DIV);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_SE0A, S_SE0B, S_J} state_t;

    state_t      state_q, state_d;
    logic        line_q, line_d;
    logic [7:0]  sr_q, sr_d, hold_q, hold_d;
    logic [2:0]  bits_q, bits_d, ones_q, ones_d, ones_base;
    logic        last_q, last_d, full_q, full_d, hlast_q, hlast_d;
    logic        show_q, show_d, pend_q, pend_d, load;
    logic [FW-1:0] frame_q;
    logic [LW-1:0] ls_q;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        sr_d      = sr_q;
        bits_d    = bits_q;
        ones_d    = ones_q;
        last_d    = last_q;
        hold_d    = hold_q;
        full_d    = full_q;
        hlast_d   = hlast_q;
        show_d    = 1'b0;
        pend_d    = 1'b0;
        // a held byte starts a packet from idle, or follows the previous byte with no gap
        load      = full_q && (state_q == S_IDLE ||
                    (state_q == S_TX && ones_q != 3'd6 && bits_q == 3'd0 && !last_q));
        ones_base = (state_q == S_IDLE) ? 3'd0 : ones_q;
        if (sbyte_wr && !full_q && (state_q == S_IDLE || state_q == S_TX)) begin
            hold_d  = sbyte;
            full_d  = 1'b1;
            hlast_d = last_pkt_byte;
        end
        if (load) begin
            state_d = S_TX;
            line_d  = hold_q[0] ? line_q : ~line_q;
            ones_d  = hold_q[0] ? ones_base + 3'd1 : 3'd0;
            sr_d    = {1'b0, hold_q[7:1]};
            bits_d  = 3'd7;
            last_d  = hlast_q;
            full_d  = 1'b0;
            show_d  = 1'b1;
        end else begin
            case (state_q)
                S_TX: begin
                    if (ones_q == 3'd6) begin
                        line_d = ~line_q;
                        ones_d = 3'd0;
                    end else if (bits_q != 3'd0) begin
                        line_d = sr_q[0] ? line_q : ~line_q;
                        ones_d = sr_q[0] ? ones_q + 3'd1 : 3'd0;
                        sr_d   = sr_q >> 1;
                        bits_d = bits_q - 3'd1;
                    end else begin
                        state_d = S_SE0A;
                    end
                end
                S_SE0A: state_d = S_SE0B;
                S_SE0B: begin
                    state_d = S_J;
                    line_d  = 1'b1;
                end
                S_J: begin
                    state_d = S_IDLE;
                    pend_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= 1'b1;
            sr_q    <= '0;
            bits_q  <= '0;
            ones_q  <= '0;
            last_q  <= 1'b0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            hlast_q <= 1'b0;
            show_q  <= 1'b0;
            pend_q  <= 1'b0;
            frame_q <= '0;
            ls_q    <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            sr_q    <= sr_d;
            bits_q  <= bits_d;
            ones_q  <= ones_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            hlast_q <= hlast_d;
            show_q  <= show_d;
            pend_q  <= pend_d;
            frame_q <= (frame_q == FW'(FRAME_LEN - 1)) ? '0 : frame_q + FW'(1);
            ls_q    <= (ls_q == LW'(LS_DIV - 1)) ? '0 : ls_q + LW'(1);
        end
    end

    logic se0;
    assign se0         = (state_q == S_SE0A) || (state_q == S_SE0B);
    assign dp          = line_q & ~se0;
    assign dm          = ~line_q & ~se0;
    assign bus_enable  = (state_q != S_IDLE);
    assign show_next   = show_q;
    assign pkt_end     = pend_q;
    assign eof         = (frame_q == FW'(FRAME_LEN - 1));
    assign eof_ena     = (frame_q >= FW'(FRAME_LEN - EOF_GUARD));
    assign ls_bit_time = (ls_q == LW'(LS_DIV - 1));
endmodule

// File: tb/tb_usb11_serializer.sv
// tb_usb11_serializer: table-driven and randomized packet checks against a bit-level line model,
// plus per-cycle frame timer and low-speed strobe checks.
module tb_usb11_serializer;
    localparam int FL = 12000;
    localparam int EG = 64;
    localparam int LD = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] sbyte = '0;
    logic sbyte_wr = 1'b0, last_pkt_byte = 1'b0;
    logic dp, dm, bus_enable, show_next, pkt_end, ls_bit_time, eof, eof_ena;

    usb11_serializer #(.FRAME_LEN(FL), .EOF_GUARD(EG), .LS_DIV(LD)) dut (
        .clk(clk), .rst(rst), .sbyte(sbyte), .sbyte_wr(sbyte_wr), .last_pkt_byte(last_pkt_byte),
        .dp(dp), .dm(dm), .bus_enable(bus_enable), .show_next(show_next), .pkt_end(pkt_end),
        .ls_bit_time(ls_bit_time), .eof(eof), .eof_ena(eof_ena)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // cycles since reset release, used by the frame/strobe model
    int k = 0, first_eof = -1, ena_cnt = 0;
    always @(posedge clk) k <= rst ? 0 : k + 1;
    always @(negedge clk) begin
        if (!rst) begin
            if (eof_ena && first_eof < 0) ena_cnt++;
            if (eof && first_eof < 0) first_eof = k;
            chk("timers", int'({eof, eof_ena, ls_bit_time}),
                int'({(k % FL) == FL - 1, (k % FL) >= FL - EG, (k % LD) == LD - 1}));
        end
    end

    logic [1:0] cap[$];
    int sn_cnt = 0, pe_cnt = 0, pe_bad = 0;
    always @(negedge clk) begin
        if (bus_enable) cap.push_back({dp, dm});
        if (show_next) sn_cnt++;
        if (pkt_end) begin
            pe_cnt++;
            if (bus_enable) pe_bad++;
        end
    end

    logic [7:0] pb[4];
    logic [1:0] exp_q[$];

    task automatic build_exp(input int n);
        logic ln;
        int ones;
        exp_q.delete();
        ln = 1'b1;
        ones = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) begin
                if (!pb[i][j]) ln = ~ln;
                exp_q.push_back({ln, ~ln});
                ones = pb[i][j] ? ones + 1 : 0;
                if (ones == 6) begin
                    ln = ~ln;
                    exp_q.push_back({ln, ~ln});
                    ones = 0;
                end
            end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    task automatic compare(input string nm, input int n);
        int bad;
        build_exp(n);
        bad = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (bad < 0 && cap[i] != exp_q[i]) bad = i;
        chk({nm, "_len"}, cap.size(), exp_q.size());
        chk({nm, "_first_bad_bit"}, bad, -1);
        chk({nm, "_pkt_end"}, pe_cnt, 1);
        chk({nm, "_pkt_end_en_low"}, pe_bad, 0);
    endtask

    task automatic wr(input logic [7:0] b, input logic l);
        sbyte = b;
        last_pkt_byte = l;
        sbyte_wr = 1'b1;
        @(negedge clk);
        sbyte_wr = 1'b0;
        last_pkt_byte = 1'b0;
    endtask

    task automatic wait_pkt_end(input string nm);
        int t;
        t = 0;
        while (!pkt_end && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_pkt_end_timeout"}, int'(t < 200), 1);
        @(negedge clk);
    endtask

    task automatic run_pkt(input string nm, input int n, input logic ml);
        int t;
        cap.delete();
        sn_cnt = 0;
        pe_cnt = 0;
        pe_bad = 0;
        wr(pb[0], n == 1 && ml);
        for (int i = 1; i < n; i++) begin
            t = 0;
            while (!show_next && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk({nm, "_show_next_timeout"}, int'(t < 40), 1);
            wr(pb[i], i == n - 1 && ml);
        end
        wait_pkt_end(nm);
        compare(nm, n);
        chk({nm, "_show_next_count"}, sn_cnt, n);
    endtask

    typedef struct {
        logic [31:0] bytes;
        int n;
        logic ml;
        int exp_len;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, t;
        logic ml;
        tbl[0] = '{32'h0000_5A80, 2, 1'b1, 19};
        tbl[1] = '{32'h0001_FF80, 3, 1'b1, 28};
        tbl[2] = '{32'h0000_0080, 1, 1'b0, 11};
        tbl[3] = '{32'hFFFF_FF80, 4, 1'b1, 39};
        tbl[4] = '{32'h0000_7E80, 2, 1'b1, 20};
        tbl[5] = '{32'h0000_FC80, 2, 1'b1, 20};

        repeat (20) @(negedge clk);
        chk("rst_dp", dp, 1);
        chk("rst_dm", dm, 0);
        chk("rst_outs", int'({bus_enable, show_next, pkt_end, eof, eof_ena, ls_bit_time}), 0);
        rst = 1'b0;
        repeat (12100) @(negedge clk);
        chk("first_eof_cycle", first_eof, FL - 1);
        chk("first_frame_eof_ena_cycles", ena_cnt, EG);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) pb[i] = tbl[v].bytes[8*i +: 8];
            run_pkt($sformatf("vec%0d", v), tbl[v].n, tbl[v].ml);
            chk($sformatf("vec%0d_enabled_cycles", v), cap.size(), tbl[v].exp_len);
        end

        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, 4);
            ml = 1'($urandom % 2);
            pb[0] = 8'h80;
            for (int i = 1; i < 4; i++) pb[i] = 8'($urandom);
            run_pkt($sformatf("rnd%0d", r), n, ml);
        end

        wr(8'h80, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_dp", dp, 1);
        chk("abort_dm", dm, 0);
        chk("abort_en", bus_enable, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pb[0] = 8'h80;
        pb[1] = 8'h5A;
        run_pkt("after_abort", 2, 1'b1);

        cap.delete();
        sn_cnt = 0;
        pe_cnt = 0;
        pe_bad = 0;
        wr(8'h80, 1'b0);
        t = 0;
        while (!show_next && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("hold_show_next_timeout", int'(t < 40), 1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b1);
        wait_pkt_end("hold_full");
        pb[0] = 8'h80;
        pb[1] = 8'h11;
        compare("hold_full", 2);
        chk("hold_full_show_next_count", sn_cnt, 2);
        n = cap.size();
        repeat (20) @(negedge clk);
        chk("hold_full_no_extra_packet", cap.size(), n);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
